// File: rtl/ga_rand_gen_multi.sv
// Multi-lane 64-bit Galois LFSR random word generator with seed loading,
// warm-up phase, free-running / on-demand modes and an accepted-draw counter.

module ga_rand_lane #(
  parameter int          OUT_W    = 42,
  parameter logic [63:0] RST_SEED = 64'h1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             load,
  input  logic             step,
  input  logic [63:0]      seed,
  output logic [OUT_W-1:0] word
);
  localparam logic [63:0] POLY   = 64'hD800_0000_0000_0000;
  // An all-zero state would lock the LFSR, so zero seeds become 1.
  localparam logic [63:0] RST_NZ = (RST_SEED == 64'h0) ? 64'h1 : RST_SEED;

  logic [63:0] state_q, state_d, seed_nz, nxt;

  always_comb begin
    seed_nz = (seed == 64'h0) ? 64'h1 : seed;
    nxt     = (state_q >> 1) ^ (state_q[0] ? POLY : 64'h0);
    state_d = state_q;
    if (clr)       state_d = RST_NZ;
    else if (load) state_d = seed_nz;
    else if (step) state_d = nxt;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= RST_NZ;
    else       state_q <= state_d;
  end

  assign word = state_q[OUT_W-1:0];
endmodule

module ga_rand_gen_multi #(
  parameter int          SIM_DLY      = 1,
  parameter int          OUT_W        = 42,
  parameter int          N_LANES      = 2,
  parameter int          WARMUP_CYC   = 16,
  parameter logic [63:0] DEFAULT_SEED = 64'h0123_4567_89AB_CDEF
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     sw_rst,
  input  logic                     mode,
  input  logic                     seed_load,
  input  logic [2:0]               seed_lane,
  input  logic [63:0]              seed_data,
  input  logic                     rand_rdy,
  output logic                     rand_vld,
  output logic [N_LANES*OUT_W-1:0] rand_data,
  output logic [31:0]              draw_cnt,
  output logic                     busy
);
  typedef enum logic {WARMUP, RUN} state_e;

  localparam state_e     RST_ST = (WARMUP_CYC == 0) ? RUN : WARMUP;
  localparam logic [7:0] WU     = 8'(WARMUP_CYC);

  // Register timing is modelled at zero delay; a negative value is meaningless.
  if (SIM_DLY < 0) begin : g_bad_sim_dly
  end

  state_e      st_q, st_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        rand_vld_q, rand_vld_d;
  logic [31:0] draw_cnt_q, draw_cnt_d;
  logic        ld_vld, hs, step;

  assign ld_vld = seed_load && ({29'd0, seed_lane} < 32'(N_LANES));
  assign hs     = rand_vld_q && rand_rdy;
  // In RUN nothing advances until the current word has been presented once.
  assign step   = !sw_rst && !ld_vld &&
                  ((st_q == WARMUP) ||
                   (rand_vld_q && (mode || rand_rdy)));

  always_comb begin
    st_d       = st_q;
    cnt_d      = cnt_q;
    rand_vld_d = rand_vld_q;
    draw_cnt_d = draw_cnt_q;
    if (sw_rst || ld_vld) begin
      st_d       = RST_ST;
      cnt_d      = WU;
      rand_vld_d = 1'b0;
      if (sw_rst) draw_cnt_d = 32'd0;
    end else begin
      case (st_q)
        WARMUP: begin
          cnt_d = cnt_q - 8'd1;
          if (cnt_q <= 8'd1) begin
            st_d       = RUN;
            rand_vld_d = 1'b1;
          end
        end
        default: begin
          rand_vld_d = 1'b1;
          if (hs) draw_cnt_d = draw_cnt_q + 32'd1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      st_q       <= RST_ST;
      cnt_q      <= WU;
      rand_vld_q <= 1'b0;
      draw_cnt_q <= 32'd0;
    end else begin
      st_q       <= st_d;
      cnt_q      <= cnt_d;
      rand_vld_q <= rand_vld_d;
      draw_cnt_q <= draw_cnt_d;
    end
  end

  logic [N_LANES-1:0][OUT_W-1:0] lane_word;

  for (genvar g = 0; g < N_LANES; g++) begin : g_lane
    ga_rand_lane #(
      .OUT_W   (OUT_W),
      .RST_SEED(DEFAULT_SEED + 64'(g))
    ) u_lane (
      .clk  (clk),
      .rstn (rstn),
      .clr  (sw_rst),
      .load (ld_vld && (seed_lane == 3'(g))),
      .step (step),
      .seed (seed_data),
      .word (lane_word[g])
    );
    assign rand_data[g*OUT_W +: OUT_W] = lane_word[g];
  end

  assign rand_vld = rand_vld_q;
  assign draw_cnt = draw_cnt_q;
  assign busy     = (st_q == WARMUP);
endmodule
